// File: rtl/demux_stream_1n_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_1n_if
// Purpose  : Producer-side and consumer-side handshake bundle for the 1:N
//            stream demultiplexer (in_bcast present with DEMUX_BCAST_EN).
// Revision : 1.0 - initial release
// ============================================================================
interface demux_stream_1n_if #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]   in_data;
    logic [SW-1:0]  in_sel;
    logic           in_valid;
    logic           in_ready;
`ifdef DEMUX_BCAST_EN
    logic           in_bcast;
`endif
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [7:0]     drop_cnt;

    modport master (
`ifdef DEMUX_BCAST_EN
        output in_bcast,
`endif
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt
    );

    modport slave (
`ifdef DEMUX_BCAST_EN
        input  in_bcast,
`endif
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/demux_stream_1n.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_1n
// Purpose  : Registered 1:N valid/ready stream demux, one holding slot per
//            channel. Optional broadcast enabled by macro DEMUX_BCAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_1n #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    demux_stream_1n_if.slave   bus
);
    logic [N-1:0][W-1:0] data_q, data_d;
    logic [N-1:0]        valid_q, valid_d;
    logic [7:0]          drop_q, drop_d;

    logic [N-1:0]        can_take;
    logic [N-1:0]        load;
    logic                sel_ok;
    logic                bcast;
    logic                ready;
    logic                xfer;

`ifdef DEMUX_BCAST_EN
    assign bcast = bus.in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // A slot accepts when empty or emptying this cycle, which gives one
    // beat per cycle per channel with no bubble.
    assign can_take = ~valid_q | bus.out_ready;
    assign sel_ok   = (int'(bus.in_sel) < N);

    always_comb begin
        ready = 1'b1;
        if (bcast) begin
            ready = &can_take;
        end else if (sel_ok) begin
            ready = can_take[bus.in_sel];
        end
    end

    assign xfer = bus.in_valid & ready;

    always_comb begin
        load    = '0;
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < N; k++) begin
            load[k]    = xfer & (bcast | (sel_ok & (int'(bus.in_sel) == k)));
            valid_d[k] = load[k] | (valid_q[k] & ~bus.out_ready[k]);
            if (load[k]) begin
                data_d[k] = bus.in_data;
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (xfer && !bcast && !sel_ok && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            drop_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.drop_cnt  = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1n.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_stream_1n
// Purpose  : Self-checking bench: N=4 instance with per-channel scoreboard,
//            N=3 instance for out-of-range drops. Broadcast with DEMUX_BCAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_stream_1n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_bcast = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    demux_stream_1n_if #(.W(8), .N(4)) bus4 ();
    demux_stream_1n_if #(.W(8), .N(3)) bus3 ();

`ifdef DEMUX_BCAST_EN
    assign bus4.in_bcast = tb_bcast;
    assign bus3.in_bcast = 1'b0;
`endif

    demux_stream_1n #(.W(8), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    demux_stream_1n #(.W(8), .N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    always #5 clk = ~clk;

    // Per-channel expected beats, pushed on input transfer, popped on output transfer.
    logic [7:0] sbq[4][$];
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) sbq[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus4.out_valid[k] && bus4.out_ready[k]) begin
                    n_checks++;
                    if (sbq[k].size() == 0) begin
                        $display("FAIL sb_ch%0d: got beat %02h, required no beat", k, bus4.out_data[k*8 +: 8]);
                    end else begin
                        mon_exp = sbq[k].pop_front();
                        if (bus4.out_data[k*8 +: 8] !== mon_exp)
                            $display("FAIL sb_ch%0d: got %02h, required %02h", k, bus4.out_data[k*8 +: 8], mon_exp);
                        else
                            n_pass++;
                    end
                end
            end
            if (bus4.in_valid && bus4.in_ready) begin
                if (tb_bcast) begin
                    for (int k = 0; k < 4; k++) sbq[k].push_back(bus4.in_data);
                end else begin
                    sbq[bus4.in_sel].push_back(bus4.in_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus4.in_valid = 1'b1; bus4.in_sel = 2'd0; bus4.in_data = 8'h11; bus4.out_ready = 4'hF;
        bus3.in_valid = 1'b0; bus3.in_sel = 2'd0; bus3.in_data = 8'h00; bus3.out_ready = 3'h7;
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0000) $display("FAIL rst_valid: got %b, required 0000", bus4.out_valid); else n_pass++;
        n_checks++;
        if (bus4.out_data !== 32'h0) $display("FAIL rst_data: got %08h, required 00000000", bus4.out_data); else n_pass++;
        n_checks++;
        if (bus4.drop_cnt !== 8'd0 || bus3.drop_cnt !== 8'd0)
            $display("FAIL rst_drop: got %0d/%0d, required 0/0", bus4.drop_cnt, bus3.drop_cnt);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0001 || bus4.out_data[7:0] !== 8'h11)
            $display("FAIL rst_first_xfer: got v=%b d=%02h, required v=0001 d=11", bus4.out_valid, bus4.out_data[7:0]);
        else n_pass++;
        bus4.in_valid = 1'b0;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0000) $display("FAIL rst_drain: got %b, required 0000", bus4.out_valid); else n_pass++;
    endtask

    task automatic test_unicast();
        bus4.out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1; bus4.in_sel = 2'(i); bus4.in_data = 8'hA0 + 8'(i);
            #1;
            n_checks++;
            if (bus4.in_ready !== 1'b1) $display("FAIL uni_ready%0d: got %b, required 1", i, bus4.in_ready); else n_pass++;
            tick();
            n_checks++;
            if (bus4.out_valid !== (4'b0001 << i) || bus4.out_data[i*8 +: 8] !== (8'hA0 + 8'(i)))
                $display("FAIL uni_ch%0d: got v=%b d=%02h, required v=%b d=%02h", i, bus4.out_valid,
                         bus4.out_data[i*8 +: 8], 4'b0001 << i, 8'hA0 + 8'(i));
            else n_pass++;
        end
        bus4.in_valid = 1'b0;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0000) $display("FAIL uni_idle: got %b, required 0000", bus4.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus4.out_ready = 4'b1011;
        bus4.in_valid = 1'b1; bus4.in_sel = 2'd2; bus4.in_data = 8'h55;
        #1;
        n_checks++;
        if (bus4.in_ready !== 1'b1) $display("FAIL bp_first_ready: got %b, required 1", bus4.in_ready); else n_pass++;
        tick();
        bus4.in_data = 8'h66;
        #1;
        n_checks++;
        if (bus4.in_ready !== 1'b0) $display("FAIL bp_stall_ready: got %b, required 0", bus4.in_ready); else n_pass++;
        tick();
        n_checks++;
        if (bus4.out_valid[2] !== 1'b1 || bus4.out_data[23:16] !== 8'h55)
            $display("FAIL bp_hold: got v=%b d=%02h, required v=1 d=55", bus4.out_valid[2], bus4.out_data[23:16]);
        else n_pass++;
        bus4.in_sel = 2'd0; bus4.in_data = 8'h77;
        #1;
        n_checks++;
        if (bus4.in_ready !== 1'b1) $display("FAIL bp_ch0_ready: got %b, required 1", bus4.in_ready); else n_pass++;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0101 || bus4.out_data[7:0] !== 8'h77 || bus4.out_data[23:16] !== 8'h55)
            $display("FAIL bp_ch0_indep: got v=%b d0=%02h d2=%02h, required v=0101 d0=77 d2=55",
                     bus4.out_valid, bus4.out_data[7:0], bus4.out_data[23:16]);
        else n_pass++;
        bus4.in_sel = 2'd2; bus4.in_data = 8'h66; bus4.out_ready = 4'b1111;
        #1;
        n_checks++;
        if (bus4.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b, required 1", bus4.in_ready); else n_pass++;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0100 || bus4.out_data[23:16] !== 8'h66)
            $display("FAIL bp_no_bubble: got v=%b d2=%02h, required v=0100 d2=66", bus4.out_valid, bus4.out_data[23:16]);
        else n_pass++;
        bus4.in_valid = 1'b0;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0000 || bus4.out_data[23:16] !== 8'h66)
            $display("FAIL bp_retain: got v=%b d2=%02h, required v=0000 d2=66", bus4.out_valid, bus4.out_data[23:16]);
        else n_pass++;
    endtask

    task automatic test_drop();
        int bad = 0;
        bus3.out_ready = 3'b111;
        bus3.in_valid = 1'b1; bus3.in_sel = 2'd3; bus3.in_data = 8'hEE;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus3.in_ready !== 1'b1) bad++;
            tick();
            if (bus3.out_valid !== 3'b000) bad++;
            if (i == 9) begin
                n_checks++;
                if (bus3.drop_cnt !== 8'd10) $display("FAIL drop_mid: got %0d, required 10", bus3.drop_cnt); else n_pass++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL drop_flow: got %0d bad cycles, required 0", bad); else n_pass++;
        n_checks++;
        if (bus3.drop_cnt !== 8'd255) $display("FAIL drop_sat: got %0d, required 255", bus3.drop_cnt); else n_pass++;
        tick();
        bus3.in_valid = 1'b0;
        n_checks++;
        if (bus3.drop_cnt !== 8'd255 || bus4.drop_cnt !== 8'd0)
            $display("FAIL drop_hold: got %0d/%0d, required 255/0", bus3.drop_cnt, bus4.drop_cnt);
        else n_pass++;
    endtask

`ifdef DEMUX_BCAST_EN
    task automatic test_bcast();
        bus4.out_ready = 4'b1101;
        bus4.in_valid = 1'b1; bus4.in_sel = 2'd1; bus4.in_data = 8'h10;
        tick();
        tb_bcast = 1'b1; bus4.in_sel = 2'd3; bus4.in_data = 8'h3C;
        #1;
        n_checks++;
        if (bus4.in_ready !== 1'b0) $display("FAIL bc_stall_ready: got %b, required 0", bus4.in_ready); else n_pass++;
        tick();
        bus4.out_ready = 4'b1111;
        #1;
        n_checks++;
        if (bus4.in_ready !== 1'b1) $display("FAIL bc_release_ready: got %b, required 1", bus4.in_ready); else n_pass++;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b1111 || bus4.out_data !== 32'h3C3C3C3C)
            $display("FAIL bc_all: got v=%b d=%08h, required v=1111 d=3c3c3c3c", bus4.out_valid, bus4.out_data);
        else n_pass++;
        bus4.in_valid = 1'b0; tb_bcast = 1'b0;
        tick();
    endtask
`endif

    task automatic test_drain_idle();
        bus4.in_valid = 1'b0; bus4.out_ready = 4'hF;
        tick(); tick();
        n_checks++;
        if (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() != 0)
            $display("FAIL sb_leftover: got %0d beats undelivered, required 0",
                     sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus4.out_ready = 4'b0000;
        bus4.in_valid = 1'b1; bus4.in_sel = 2'd0; bus4.in_data = 8'h01;
        tick();
        bus4.in_sel = 2'd1; bus4.in_data = 8'h02;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0011) $display("FAIL rm_fill: got %b, required 0011", bus4.out_valid); else n_pass++;
        bus4.out_ready = 4'b0011; bus4.in_sel = 2'd3; bus4.in_data = 8'h03;
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0000 || bus4.out_data !== 32'h0)
            $display("FAIL rm_clear: got v=%b d=%08h, required v=0000 d=00000000", bus4.out_valid, bus4.out_data);
        else n_pass++;
        rst = 1'b0; bus4.in_valid = 1'b0;
        tick();
        n_checks++;
        if (bus4.out_valid !== 4'b0000) $display("FAIL rm_lost: got %b, required 0000", bus4.out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_back_to_back();
        test_drop();
`ifdef DEMUX_BCAST_EN
        test_bcast();
`endif
        test_drain_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/demux_stream_1n.md
# demux_stream_1n

Parametrised 1-to-N stream demultiplexer, the registered, flow-controlled successor of the 1:4 combinational demux. It accepts one beat per cycle on a valid/ready input, steers it by a channel select into a one-entry holding register on the chosen output channel, and presents it there under that channel's own valid/ready handshake. It sits between a single producer and N independent consumers; back-pressure on one channel never blocks the others except when the input targets it.

## Interface
- W, default 8: data width in bits.
- N, default 4: number of output channels, 2..16; select width SW = max(1, ceil(log2(N))), derived locally.
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  input beat payload.
- in_sel  input  SW  destination channel index, 0..N-1.
- in_valid  input  1  producer offers a beat.
- in_ready  output  1  block accepts the beat this cycle (transfer = in_valid & in_ready).
- in_bcast  input  1  broadcast request; present only when DEMUX_BCAST_EN is defined.
- out_data  output  N*W  channel k payload on bits [k*W +: W].
- out_valid  output  N  channel k holds a beat.
- out_ready  input  N  consumer k takes the beat (transfer = out_valid[k] & out_ready[k]).
- drop_cnt  output  8  count of beats dropped for out-of-range select, saturating.

## Operation
- Per channel k: one holding register data_k plus valid bit v_k; out_data slice = data_k, out_valid[k] = v_k.
- Channel k can take a new beat when !v_k or out_ready[k] (slot empty or draining this cycle).
- Unicast (in_sel < N): in_ready = can-take of channel in_sel; on transfer data_k <= in_data, v_k <= 1.
- Out-of-range select (in_sel >= N, only possible when N not a power of two): in_ready = 1; beat discarded; drop_cnt increments, holds at 255.
- Channel drain with no refill: v_k <= 0 on output transfer; data_k retains its value.
- Simultaneous drain and refill on same channel in the same cycle: v_k stays 1, data_k takes the new beat; full throughput of one beat per cycle per channel.
- Non-selected channels are unaffected by input traffic; their drains proceed independently.
- While v_k = 1 and out_ready[k] = 0, data_k and v_k are held stable.
- in_ready is combinational from in_sel, v, out_ready; no combinational path from in_data.
- Beats on one channel leave in acceptance order; no ordering across channels.

## Timing
- Reset (rst high at a clock edge): out_valid = 0, out_data = 0, drop_cnt = 0; any buffered beats are discarded; in_ready during reset cycle is don't-care, first valid acceptance is the edge after rst deasserts.
- Latency: beat accepted at edge t appears on out_valid/out_data after edge t, i.e. 1 cycle.
- Reset asserted mid-operation overrides every concurrent input or output transfer in that cycle.
- drop_cnt updates at the same edge as the dropped transfer.

## Configuration
- DEMUX_BCAST_EN defined: in_bcast port exists. When in_valid & in_bcast, in_sel is ignored; in_ready = AND of can-take over all N channels; on transfer every channel loads in_data and sets its valid. Out-of-range select never counts as a drop while in_bcast = 1.
- DEMUX_BCAST_EN undefined: no in_bcast port; unicast-only behaviour above.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0000, out_data=0, drop_cnt=0; first transfer only after rst low.
- Unicast sweep N=4, W=8, out_ready=1111: send 0xA0..0xA3 with in_sel 0..3 on consecutive cycles -> each channel out_valid pulses 1 cycle after its beat with matching data, in_ready stays 1.
- Back-pressure: out_ready[2]=0, send 0x55 then 0x66 to channel 2 -> 0x55 held on channel 2, in_ready=0 for second beat until out_ready[2]=1, then 0x66 loads same cycle 0x55 drains, no bubble; channel 0 traffic meanwhile unaffected.
- Drop: N=3, send 300 beats with in_sel=3 -> in_ready=1 throughout, no out_valid change, drop_cnt=255 and holds.
- Reset mid-operation: channels 0 and 1 full and stalled, assert rst with a concurrent transfer -> out_valid=0 next cycle, transfer lost.
- Broadcast (DEMUX_BCAST_EN): in_bcast=1 data 0x3C with out_ready[1]=0 and channel 1 full -> in_ready=0; release out_ready[1] -> all four channels show 0x3C one cycle later.
